// File: rtl/serial_adder_pkg.sv
// -----------------------------------------------------------------------------
// serial_adder_pkg
//   Shared definitions for the bit-serial arithmetic units (this adder and the
//   ripple-borrow subtractor).
//   - state_t       : control FSM encoding (IDLE / SHIFT / DONE)
//   - DEFAULT_WIDTH : default operand width shared by both units
//   - cnt_width()   : bit counter width needed to count 0 .. width
// -----------------------------------------------------------------------------
package serial_adder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 6;

  // Counter width for a counter that must be able to hold the value 'width'.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage : serial_adder_pkg

// File: rtl/serial_adder_fulladd.sv
// -----------------------------------------------------------------------------
// fullAdd
//   One-bit full adder built from two half-adder stages and an OR gate,
//   mirroring the half/full difference cells of the subtractor.
//   Ports:
//     a, b   : operand bits
//     cin    : carry in
//     sum    : a ^ b ^ cin
//     carry  : carry out
// -----------------------------------------------------------------------------
module fullAdd (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic carry
);

  logic ha1_sum_s;
  logic ha1_carry_s;
  logic ha2_carry_s;

  // First half adder: a + b
  assign ha1_sum_s   = a ^ b;
  assign ha1_carry_s = a & b;

  // Second half adder: partial sum + cin
  assign sum         = ha1_sum_s ^ cin;
  assign ha2_carry_s = ha1_sum_s & cin;

  // At most one half-adder stage can generate a carry, so OR merges them.
  assign carry       = ha1_carry_s | ha2_carry_s;

endmodule : fullAdd

// File: rtl/serial_adder.sv
// -----------------------------------------------------------------------------
// serial_adder
//   Bit-serial unsigned adder: one full-adder cell and a carry flip-flop,
//   processing one operand bit per clock, LSB first.
//   Ports:
//     clk    : clock, rising edge
//     reset  : asynchronous, active-high reset
//     start  : request, sampled only in IDLE
//     x, y   : WIDTH-bit operands, captured on the accepted start edge
//     busy   : high while in SHIFT or DONE
//     done   : one-cycle pulse, sum valid
//     sum    : {carry_out, sum_bits}, held until the next completion
//   Timing: start accepted at edge k -> bits processed on edges k+1..k+WIDTH,
//   done/sum updated after edge k+WIDTH, back in IDLE after edge k+WIDTH+1.
// -----------------------------------------------------------------------------
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic             busy,
  output logic             done,
  output logic [WIDTH:0]   sum
);

  localparam int CW = cnt_width(WIDTH);

  state_t           state_r;
  logic [WIDTH-1:0] xs_r;
  logic [WIDTH-1:0] ys_r;
  // Holds the WIDTH-1 low result bits already produced; the final bit comes
  // straight from the adder on the last edge.
  logic [WIDTH-2:0] acc_r;
  logic             c_r;
  logic [CW-1:0]    cnt_r;
  logic             busy_r;
  logic             done_r;
  logic [WIDTH:0]   sum_r;

  logic             fa_sum_s;
  logic             fa_carry_s;
  logic [WIDTH-1:0] acc_next_s;
  logic             last_bit_s;

  fullAdd u_full_add (
    .a     (xs_r[0]),
    .b     (ys_r[0]),
    .cin   (c_r),
    .sum   (fa_sum_s),
    .carry (fa_carry_s)
  );

  // New sum bit enters at the MSB; after WIDTH shifts bit 0 sits at the LSB.
  assign acc_next_s = {fa_sum_s, acc_r};
  assign last_bit_s = (cnt_r == CW'(WIDTH - 1));

  assign busy = busy_r;
  assign done = done_r;
  assign sum  = sum_r;

  // Control FSM plus datapath registers and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
      xs_r    <= {WIDTH{1'b0}};
      ys_r    <= {WIDTH{1'b0}};
      acc_r   <= {(WIDTH-1){1'b0}};
      c_r     <= 1'b0;
      cnt_r   <= {CW{1'b0}};
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      sum_r   <= {(WIDTH+1){1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          done_r <= 1'b0;
          if (start) begin
            xs_r    <= x;
            ys_r    <= y;
            acc_r   <= {(WIDTH-1){1'b0}};
            c_r     <= 1'b0;
            cnt_r   <= {CW{1'b0}};
            busy_r  <= 1'b1;
            state_r <= ST_SHIFT;
          end else begin
            busy_r  <= 1'b0;
            state_r <= ST_IDLE;
          end
        end

        ST_SHIFT: begin
          xs_r  <= {1'b0, xs_r[WIDTH-1:1]};
          ys_r  <= {1'b0, ys_r[WIDTH-1:1]};
          acc_r <= acc_next_s[WIDTH-1:1];
          c_r   <= fa_carry_s;
          cnt_r <= cnt_r + CW'(1);
          if (last_bit_s) begin
            sum_r   <= {fa_carry_s, acc_next_s};
            done_r  <= 1'b1;
            state_r <= ST_DONE;
          end else begin
            state_r <= ST_SHIFT;
          end
        end

        ST_DONE: begin
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end

        default: begin
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule : serial_adder

// File: tb/tb_serial_adder.sv
// Directed self-checking bench for serial_adder (WIDTH = 6).
module tb_serial_adder;

  localparam int W = 6;

  logic         clk;
  logic         reset;
  logic         start;
  logic [W-1:0] x;
  logic [W-1:0] y;
  logic         busy;
  logic         done;
  logic [W:0]   sum;

  int errors;
  int checks;

  serial_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .x     (x),
    .y     (y),
    .busy  (busy),
    .done  (done),
    .sum   (sum)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issue one operation from IDLE and follow it back to IDLE.
  // lat: edges after the accept edge until done is seen (-1 on timeout).
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        output logic [W:0] got, output int lat,
                        output int busy_n, output bit stable, output bit idle_ok);
    logic [W:0] prev;
    prev    = sum;
    stable  = 1'b1;
    busy_n  = 0;
    lat     = -1;
    got     = 'x;
    idle_ok = 1'b0;
    @(negedge clk);
    x = a; y = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    x = ~a; y = ~b;  // operand changes after capture must not matter
    if (busy === 1'b1) busy_n++;
    if (sum !== prev) stable = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk); #1;
      if (busy === 1'b1) busy_n++;
      if (done === 1'b1) begin
        lat = n;
        got = sum;
        break;
      end
      if (sum !== prev) stable = 1'b0;
    end
    if (lat > 0) begin
      @(posedge clk); #1;
      idle_ok = (busy === 1'b0) && (done === 1'b0) && (sum === got);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; x = '0; y = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%0b exp=0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%0b exp=0", done); end
    checks++; if (sum !== 7'd0) begin errors++; $display("FAIL reset_sum got=%0d exp=0", sum); end
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_zero();
    logic [W:0] got; int lat; int bn; bit st; bit idl;
    run_op(6'd0, 6'd0, got, lat, bn, st, idl);
    checks++; if (lat !== 6) begin errors++; $display("FAIL zero_latency got=%0d exp=6", lat); end
    checks++; if (got !== 7'b0000000) begin errors++; $display("FAIL zero_sum got=%0d exp=0", got); end
    checks++; if (bn !== 7) begin errors++; $display("FAIL zero_busy_cycles got=%0d exp=7", bn); end
    checks++; if (idl !== 1'b1) begin errors++; $display("FAIL zero_return_idle got=%0b exp=1", idl); end
  endtask

  task automatic test_vectors();
    logic [W-1:0] va [3] = '{6'd45, 6'd63, 6'd63};
    logic [W-1:0] vb [3] = '{6'd27, 6'd1,  6'd63};
    logic [W:0]   ve [3] = '{7'd72, 7'd64, 7'd126};
    logic [W:0] got; int lat; int bn; bit st; bit idl;
    for (int i = 0; i < 3; i++) begin
      run_op(va[i], vb[i], got, lat, bn, st, idl);
      checks++;
      if (got !== ve[i]) begin
        errors++; $display("FAIL vector_sum %0d+%0d got=%0d exp=%0d", va[i], vb[i], got, ve[i]);
      end
      checks++;
      if (st !== 1'b1) begin
        errors++; $display("FAIL vector_sum_hold %0d+%0d got=%0b exp=1", va[i], vb[i], st);
      end
    end
  endtask

  // start held high, operands changing every cycle: accepts at edges 0,8,16,24.
  task automatic test_start_held();
    logic [W-1:0] ax [32];
    logic [W-1:0] ay [32];
    int ndone;
    int idx;
    for (int e = 0; e < 32; e++) begin
      ax[e] = W'((e * 7 + 3) % 64);
      ay[e] = W'((e * 11 + 5) % 64);
    end
    ndone = 0;
    for (int e = 0; e < 32; e++) begin
      @(negedge clk);
      x = ax[e]; y = ay[e]; start = 1'b1;
      @(posedge clk); #1;
      if (done === 1'b1) begin
        ndone++;
        checks++;
        if ((e % 8) != 6) begin
          errors++; $display("FAIL held_done_edge got=%0d exp=%0d", e, (e / 8) * 8 + 6);
        end else begin
          idx = e - 6;
          if (sum !== (7'(ax[idx]) + 7'(ay[idx]))) begin
            errors++;
            $display("FAIL held_sum got=%0d exp=%0d", sum, 7'(ax[idx]) + 7'(ay[idx]));
          end
        end
      end
    end
    checks++; if (ndone !== 4) begin errors++; $display("FAIL held_done_count got=%0d exp=4", ndone); end
    // Edge 31 is the DONE edge of the op accepted at 24... drop start and drain.
    @(negedge clk); start = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (busy === 1'b0) break;
    end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL held_drain got=%0b exp=0", busy); end
  endtask

  task automatic test_reset_mid();
    logic [W:0] got; int lat; int bn; bit st; bit idl;
    int seen;
    @(negedge clk);
    x = 6'd45; y = 6'd27; start = 1'b1;
    @(posedge clk); #1;           // accept edge k
    start = 1'b0;
    repeat (2) @(posedge clk);    // edges k+1, k+2 -> 3rd SHIFT cycle
    @(negedge clk);
    reset = 1'b1;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midreset_busy got=%0b exp=0", busy); end
    checks++; if (sum !== 7'd0) begin errors++; $display("FAIL midreset_sum got=%0d exp=0", sum); end
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1 || busy === 1'b1) seen++;
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL midreset_no_done got=%0d exp=0", seen); end
    run_op(6'd10, 6'd5, got, lat, bn, st, idl);
    checks++; if (got !== 7'd15) begin errors++; $display("FAIL after_reset_sum got=%0d exp=15", got); end
  endtask

  task automatic test_exhaustive();
    logic [W:0] got; int lat; int bn; bit st; bit idl;
    logic [W:0] exp_s;
    for (int a = 0; a < 64; a++) begin
      for (int b = 0; b < 64; b++) begin
        run_op(W'(a), W'(b), got, lat, bn, st, idl);
        exp_s = 7'(a + b);
        checks++;
        if (got !== exp_s) begin
          errors++; $display("FAIL sweep_sum %0d+%0d got=%0d exp=%0d", a, b, got, exp_s);
        end
        checks++;
        if (st !== 1'b1 || lat !== 6) begin
          errors++; $display("FAIL sweep_timing %0d+%0d stable=%0b lat=%0d exp stable=1 lat=6", a, b, st, lat);
        end
      end
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_zero();
    test_vectors();
    test_start_held();
    test_reset_mid();
    test_exhaustive();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_serial_adder
